// File: rtl/adder_sched_pkg.sv
// Shared constants and types for the adder scheduler.
// The lock state type is used only when ADDER_SCHED_CHAIN_EN is defined.
package adder_sched_pkg;
  localparam int DATA_W  = 64;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;
endpackage

// File: rtl/adder_scheduler_if.sv
// Requester bus and result bus of the adder scheduler.
// The slave modport is the scheduler. The master modport is the requester/consumer side.
interface adder_scheduler_if;
  import adder_sched_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] a_in;
  logic [NUM_REQ*DATA_W-1:0] b_in;
  logic [NUM_REQ-1:0]        cin_in;
  logic [NUM_REQ-1:0]        last_in;
  logic [NUM_REQ-1:0]        gnt;
  logic                      res_valid;
  logic                      res_ready;
  logic [ID_W-1:0]           res_id;
  logic [DATA_W-1:0]         res_sum;
  logic                      res_cout;

  modport slave (
    input  req, a_in, b_in, cin_in, last_in, res_ready,
    output gnt, res_valid, res_id, res_sum, res_cout
  );

  modport master (
    output req, a_in, b_in, cin_in, last_in, res_ready,
    input  gnt, res_valid, res_id, res_sum, res_cout
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Combinational round-robin picker.
// It grants the first requesting index at or after ptr, wrapping modulo NUM_REQ.
// The grant is one-hot, or zero when en is low.
module adder_rr_arbiter
  import adder_sched_pkg::*;
(
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  // The scan runs from the farthest offset down to offset 0.
  // As a result, the nearest request at or after ptr wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    if (en) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = ptr + k[ID_W-1:0];
        if (req[idx]) begin
          gnt_id  = idx;
          gnt_any = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign gnt[gi] = gnt_any && (gnt_id == ID_W'(gi));
  end

endmodule

// File: rtl/carry_skip_64bit.sv
// 64-bit carry-skip adder built from 4-bit ripple blocks.
// A block whose bits all propagate passes its carry-in straight through as its carry-out.
module carry_skip_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  localparam int BLK  = 4;
  localparam int NBLK = 64 / BLK;

  for (genvar gi = 0; gi < NBLK; gi++) begin : blk
    logic           c_in;
    logic           c_out;
    logic [BLK-1:0] s;

    if (gi == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_chain
      assign c_in = blk[gi-1].c_out;
    end

    // Ripple through the block.
    // The skip multiplexer bypasses the ripple when the whole block propagates.
    always_comb begin
      logic c;
      logic prop;
      c    = c_in;
      prop = 1'b1;
      s    = '0;
      for (int j = 0; j < BLK; j++) begin
        s[j] = a[gi*BLK+j] ^ b[gi*BLK+j] ^ c;
        c    = (a[gi*BLK+j] & b[gi*BLK+j]) | (c & (a[gi*BLK+j] ^ b[gi*BLK+j]));
        prop = prop & (a[gi*BLK+j] ^ b[gi*BLK+j]);
      end
      c_out = prop ? c_in : c;
    end

    assign sum[gi*BLK +: BLK] = s;
  end

  assign cout = blk[NBLK-1].c_out;

endmodule

// File: rtl/adder_scheduler.sv
// Shares one 64-bit adder among four requesters with round-robin arbitration.
// It holds a single registered result slot.
// Defining ADDER_SCHED_CHAIN_EN enables multi-beat chained adds.
// In that mode one requester locks the adder, and each beat's carry-out feeds the next beat's carry-in.
module adder_scheduler
  import adder_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  adder_scheduler_if.slave   bus
);

  logic [DATA_W-1:0]  a_arr [NUM_REQ];
  logic [DATA_W-1:0]  b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               slot_free;
  logic               add_cin;
  logic [DATA_W-1:0]  add_sum;
  logic               add_cout;
  logic               ptr_hold;

  logic [ID_W-1:0]    rr_ptr_reg;
  logic               res_valid_reg;
  logic [ID_W-1:0]    res_id_reg;
  logic [DATA_W-1:0]  res_sum_reg;
  logic               res_cout_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
    assign a_arr[gi] = bus.a_in[gi*DATA_W +: DATA_W];
    assign b_arr[gi] = bus.b_in[gi*DATA_W +: DATA_W];
  end

  // The slot can take a new result when it is empty or being drained this cycle.
  // Grants are also held off while reset is asserted.
  assign slot_free = !res_valid_reg || bus.res_ready;

`ifdef ADDER_SCHED_CHAIN_EN
  lock_state_t     state_reg, state_next;
  logic [ID_W-1:0] owner_reg, owner_next;
  logic            carry_reg;
  logic            last_beat;

  assign arb_req   = (state_reg == LOCKED) ? (bus.req & (NUM_REQ'(1) << owner_reg)) : bus.req;
  assign add_cin   = (state_reg == LOCKED) ? carry_reg : bus.cin_in[gnt_id];
  assign last_beat = bus.last_in[gnt_id];

  // Lock FSM next state.
  // A non-last beat locks the adder to its owner; the owner's last beat releases it.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_hold   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_any && !last_beat) begin
          state_next = LOCKED;
          owner_next = gnt_id;
        end
      end
      LOCKED: begin
        if (gnt_any) begin
          if (last_beat) state_next = IDLE;
          else           ptr_hold   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lock state, owner, and the carry saved for the owner's next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      if (gnt_any) carry_reg <= add_cout;
    end
  end
`else
  logic unused_last;

  assign arb_req     = bus.req;
  assign add_cin     = bus.cin_in[gnt_id];
  assign ptr_hold    = 1'b0;
  assign unused_last = ^bus.last_in;
`endif

  adder_rr_arbiter u_arb (
    .en      (slot_free && rst_n),
    .req     (arb_req),
    .ptr     (rr_ptr_reg),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  carry_skip_64bit u_add (
    .a    (a_arr[gnt_id]),
    .b    (b_arr[gnt_id]),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The round-robin pointer moves past each grantee.
  // It does not move on the intermediate beats of a chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   rr_ptr_reg <= '0;
    else if (gnt_any && !ptr_hold) rr_ptr_reg <= gnt_id + ID_W'(1);
  end

  // Result slot: a grant loads it, and an accept with no grant empties it.
  // Otherwise the slot holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      res_sum_reg   <= '0;
      res_cout_reg  <= 1'b0;
    end else if (gnt_any) begin
      res_valid_reg <= 1'b1;
      res_id_reg    <= gnt_id;
      res_sum_reg   <= add_sum;
      res_cout_reg  <= add_cout;
    end else if (res_valid_reg && bus.res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.res_sum   = res_sum_reg;
  assign bus.res_cout  = res_cout_reg;

endmodule

// File: tb/tb_adder_scheduler.sv
// Randomised bench for adder_scheduler with a behavioural reference model.
// Directed literal checks pin down the reference model.
// Chain checks are included when ADDER_SCHED_CHAIN_EN is defined.
module tb_adder_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  adder_scheduler_if bus();

  adder_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // Reference model state, described in the specification's terms.
  logic        m_valid  = 1'b0;
  logic [63:0] m_sum    = '0;
  logic        m_cout   = 1'b0;
  int          m_id     = 0;
  int          m_ptr    = 0;
  logic        m_locked = 1'b0;
  int          m_owner  = 0;
  logic        m_carry  = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected grant: the first requester at or after the pointer, or only the lock owner.
  // No grant while reset is low or while the slot is not free.
  function automatic int model_pick();
    if (!rst_n) return -1;
    if (m_valid && !bus.res_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (bus.req[i] && (!m_locked || i == m_owner)) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt();
    int i;
    i = model_pick();
    return (i < 0) ? 4'b0000 : 4'(1 << i);
  endfunction

  // Advance the model once per clock edge; an asynchronous reset clears it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 0; m_sum = '0; m_cout = 0; m_id = 0;
      m_ptr = 0; m_locked = 0; m_owner = 0; m_carry = 0;
    end else begin
      int i;
      i = model_pick();
      if (i >= 0) begin
        logic [64:0] full;
        logic        c;
        logic        last;
        logic        was_locked;
        was_locked = m_locked;
        c = m_locked ? m_carry : bus.cin_in[i];
        full = {1'b0, bus.a_in[i*64 +: 64]} + {1'b0, bus.b_in[i*64 +: 64]} + {64'd0, c};
        m_sum = full[63:0]; m_cout = full[64]; m_id = i; m_valid = 1; m_carry = full[64];
`ifdef ADDER_SCHED_CHAIN_EN
        last = bus.last_in[i];
`else
        last = 1'b1;
`endif
        if (!m_locked && !last) begin m_locked = 1; m_owner = i; end
        else if (m_locked && last) m_locked = 0;
        if (!(was_locked && !last)) m_ptr = (i + 1) % 4;
      end else if (m_valid && bus.res_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    check("gnt", 64'(bus.gnt), 64'(model_gnt()));
    check("res_valid", 64'(bus.res_valid), 64'(m_valid));
    check("res_id", 64'(bus.res_id), 64'(m_id[1:0]));
    check("res_sum", bus.res_sum, m_sum);
    check("res_cout", 64'(bus.res_cout), 64'(m_cout));
  end

  function automatic logic [63:0] rnd64();
    case ($urandom % 4)
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req = 4'b1111; bus.cin_in = '0; bus.last_in = 4'b1111; bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a_in[i*64 +: 64] = rnd64();
      bus.b_in[i*64 +: 64] = rnd64();
    end

    // Outputs must be quiet during reset, even with every requester asserted.
    tick(); tick();
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_sum", bus.res_sum, 64'd0);
    check("rst_id", 64'(bus.res_id), 64'd0);
    rst_n = 1'b1;

    // All four requesting with the result always accepted: strict rotation, one result per cycle.
    for (int k = 0; k < 8; k++) begin
      #2;
      check($sformatf("rr_gnt%0d", k), 64'(bus.gnt), 64'(1 << (k % 4)));
      tick();
      check($sformatf("rr_valid%0d", k), 64'(bus.res_valid), 64'd1);
      check($sformatf("rr_id%0d", k), 64'(bus.res_id), 64'(k % 4));
    end

    // Wrap-around of the 64-bit sum into the carry-out.
    bus.req = 4'b0001; bus.cin_in = 4'b0000;
    bus.a_in[63:0] = 64'hFFFF_FFFF_FFFF_FFFF; bus.b_in[63:0] = 64'd1;
    #2 check("ovf_gnt", 64'(bus.gnt), 64'b0001);
    tick();
    check("ovf_sum", bus.res_sum, 64'd0);
    check("ovf_cout", 64'(bus.res_cout), 64'd1);
    check("ovf_id", 64'(bus.res_id), 64'd0);

    // Backpressure: no grant and the result is held; accepting grants in the same cycle.
    bus.res_ready = 1'b0; bus.req = 4'b0010;
    #2 check("bp_gnt", 64'(bus.gnt), 64'd0);
    tick();
    check("bp_sum_hold", bus.res_sum, 64'd0);
    check("bp_cout_hold", 64'(bus.res_cout), 64'd1);
    check("bp_valid_hold", 64'(bus.res_valid), 64'd1);
    bus.res_ready = 1'b1;
    #1 check("bp_release_gnt", 64'(bus.gnt), 64'b0010);
    tick();
    check("bp_release_id", 64'(bus.res_id), 64'd1);

`ifdef ADDER_SCHED_CHAIN_EN
    // Two-beat chain on requester 2; requester 1 must wait until the last beat.
    bus.req = 4'b0110; bus.last_in = 4'b0000; bus.cin_in = 4'b0000;
    bus.a_in[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF; bus.b_in[128 +: 64] = 64'd1;
    #2 check("ch_gnt1", 64'(bus.gnt), 64'b0100);
    tick();
    check("ch_sum1", bus.res_sum, 64'd0);
    check("ch_id1", 64'(bus.res_id), 64'd2);
    bus.a_in[128 +: 64] = 64'd0; bus.b_in[128 +: 64] = 64'd0; bus.last_in = 4'b0100;
    #2 check("ch_gnt2", 64'(bus.gnt), 64'b0100);
    tick();
    check("ch_sum2", bus.res_sum, 64'd1);
    check("ch_id2", 64'(bus.res_id), 64'd2);
    #1 check("ch_after_gnt", 64'(bus.gnt), 64'b0010);
    tick();
`endif

    // Lock onto requester 3 (in chain mode) and then reset mid-chain.
    bus.req = 4'b1000; bus.last_in = 4'b0000;
    #2 check("lk_gnt", 64'(bus.gnt), 64'b1000);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_sum", bus.res_sum, 64'd0);
    check("mid_rst_cout", 64'(bus.res_cout), 64'd0);
    check("mid_rst_id", 64'(bus.res_id), 64'd0);
    tick();
    rst_n = 1'b1; bus.req = 4'b1001; bus.last_in = 4'b1111;
    #1 check("post_rst_gnt", 64'(bus.gnt), 64'b0001);
    tick();

    // Random traffic checked cycle by cycle against the model, with one reset pulse mid-run.
    for (int n = 0; n < 600; n++) begin
      bus.req       = 4'($urandom_range(0, 15));
      bus.res_ready = ($urandom % 4) != 0;
      bus.cin_in    = 4'($urandom_range(0, 15));
      bus.last_in   = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        bus.a_in[i*64 +: 64] = rnd64();
        bus.b_in[i*64 +: 64] = rnd64();
      end
      if (n == 300) begin
        #2 rst_n = 1'b0;
        #1 check("rnd_rst_valid", 64'(bus.res_valid), 64'd0);
      end
      if (n == 302) rst_n = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter: NUM_REQ, 4, number of requesters (fixed at 4 in this revision).
REQ-003 Parameter: DATA_W, 64, operand width (matches the shared 64-bit adder).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  4  per-requester request, level.
REQ-007 a_in  input  256  requester i operand A in bits [64i+63:64i].
REQ-008 b_in  input  256  requester i operand B in bits [64i+63:64i].
REQ-009 cin_in  input  4  per-requester carry-in.
REQ-010 last_in  input  4  per-requester last beat of a chained add (chain mode only).
REQ-011 gnt  output  4  one-hot grant; operands of granted requester are consumed on that clock edge.
REQ-012 res_valid  output  1  result register holds a valid result.
REQ-013 res_ready  input  1  downstream accepts result when res_valid and res_ready are both high.
REQ-014 res_id  output  2  index of the requester that owns the result.
REQ-015 res_sum  output  64  registered sum.
REQ-016 res_cout  output  1  registered carry-out.

Function
REQ-017 Slot free = !res_valid || res_ready; gnt SHALL be all-zero when the slot is not free.
REQ-018 When the slot is free and unlocked, gnt SHALL go to the first requesting index at or after rr_ptr, modulo 4.
REQ-019 After each grant to index i, rr_ptr SHALL become (i+1) mod 4; it SHALL be unchanged when nothing is granted.
REQ-020 gnt SHALL be combinational from req, rr_ptr, lock state and slot-free status, and SHALL be one-hot or zero.
REQ-021 On a grant edge, res_sum/res_cout SHALL load the adder result of the granted operands, res_id the grant index, and res_valid SHALL be set: latency is 1 cycle.
REQ-022 If the slot is accepted (res_valid && res_ready) with no new grant, res_valid SHALL clear.
REQ-023 Simultaneous accept and grant in one cycle SHALL replace the result with res_valid held at 1 (1 result/cycle throughput).
REQ-024 res_sum/res_cout/res_id SHALL hold stable while res_valid && !res_ready.
REQ-025 Adder carry-in SHALL be cin_in[granted] when unlocked.
REQ-026 Adder arithmetic SHALL be modulo 2^64, with overflow reported only through res_cout.

Reset
REQ-027 While rst_n is low: res_valid=0, res_sum=0, res_cout=0, res_id=0, rr_ptr=0, lock state IDLE, stored carry=0; gnt=0.
REQ-028 Reset asserted mid-chain SHALL abandon the chain; the first grant after release SHALL follow REQ-018 with rr_ptr=0.

Configuration
REQ-029 Macro ADDER_SCHED_CHAIN_EN SHALL enable multi-precision chaining; absent, last_in SHALL be ignored (treated as 1) and the FSM/carry register SHALL not exist.
REQ-030 With the macro, FSM states SHALL be IDLE and LOCKED; IDLE->LOCKED on a grant with last_in[i]=0, recording owner i; LOCKED->IDLE on an owner grant with last_in[i]=1.
REQ-031 In LOCKED, only the owner SHALL be grantable, and the adder carry-in SHALL be the stored cout of the owner's previous beat (cin_in ignored).
REQ-032 In LOCKED, owner deasserting req SHALL stall (no grant, lock kept); rr_ptr SHALL not advance on locked beats, and SHALL become owner+1 on the last beat.

Structure
REQ-033 A shared package adder_sched_pkg SHALL hold DATA_W, NUM_REQ, ID_W=2 and the IDLE/LOCKED state type.
REQ-034 Round-robin selection SHALL live in one sub-module adder_rr_arbiter; the adder SHALL be the existing carry_skip_64bit, instantiated once.

Verification
REQ-035 req=4'b1111, res_ready=1 for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; a result on every cycle after the first.
REQ-036 req0 with a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> one cycle later res_sum=0, res_cout=1, res_id=0.
REQ-037 res_valid high, res_ready=0, req=4'b0010 -> gnt=0, outputs held; res_ready=1 -> same-cycle gnt=4'b0010.
REQ-038 Chain (macro on): req2 beat1 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, last=0; beat2 a=0, b=0, last=1; req1 high throughout -> sums 0 then 1, res_id=2 both, req1 granted only after beat2.
REQ-039 Chain locked on req3, rst_n pulsed low -> all outputs at reset values; after release req=4'b1001 -> gnt=4'b0001.
